// File: rtl/rr_req_initiator.sv
// rr_req_initiator: requester side of a 4-way round-robin arbiter.
// Each channel accepts a burst command, requests the arbiter, streams its
// beats onto the shared beat bus while granted, then releases REQ for one
// cycle so the arbiter can rotate. Grant starvation and arbiter protocol
// violations are flagged with sticky status bits.
module rr_req_initiator #(
    parameter int N       = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       cmd_valid,
    input  logic [N*LEN_W-1:0] cmd_len,
    output logic [N-1:0]       cmd_ready,
    output logic [N-1:0]       REQ,
    input  logic [N-1:0]       GNT,
    output logic               beat_valid,
    output logic [1:0]         beat_id,
    output logic               beat_last,
    output logic [N-1:0]       starve,
    output logic               proto_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_REL
    } state_t;

    state_t             state_q [N];
    state_t             state_d [N];
    logic [LEN_W-1:0]   cnt_q   [N];   // beats remaining minus one
    logic [WAIT_W-1:0]  wait_q  [N];   // cycles spent requesting without grant
    logic [N-1:0]       starve_q;
    logic               proto_err_q;
    logic [1:0]         beat_id_q;

    logic               gnt_multi;
    logic               gnt_onehot;
    logic [N-1:0]       active;        // channel is asserting REQ
    logic [N-1:0]       dormant;       // channel must not be granted
    logic [N-1:0]       fire;          // channel transfers a beat this cycle

    // Decode the grant vector; a beat moves only on a clean one-hot grant
    // to a requesting channel, including the very first granted cycle.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        gnt_multi  = (GNT & (GNT - N'(1))) != '0;
        gnt_onehot = (GNT != '0) && !gnt_multi;
        active     = '0;
        dormant    = '0;
        fire       = '0;
        for (int i = 0; i < N; i++) begin
            active[i]  = (state_q[i] == S_REQ) || (state_q[i] == S_BUSY);
            dormant[i] = (state_q[i] == S_IDLE) || (state_q[i] == S_REL);
            fire[i]    = !rst && gnt_onehot && GNT[i] && active[i];
        end
    end

    // Per-channel next-state logic.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                S_IDLE: if (cmd_valid[i]) state_d[i] = S_REQ;
                S_REQ:  if (fire[i]) state_d[i] = (cnt_q[i] == '0) ? S_REL : S_BUSY;
                S_BUSY: if (fire[i] && cnt_q[i] == '0) state_d[i] = S_REL;
                S_REL:  state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            for (int i = 0; i < N; i++) state_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
        end
    end

    // Beat/wait counters, sticky status flags and the held beat_id.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
            starve_q    <= '0;
            proto_err_q <= 1'b0;
            beat_id_q   <= '0;
        end else begin
            beat_id_q   <= beat_id;
            proto_err_q <= proto_err_q | gnt_multi | (|(GNT & dormant));
            for (int i = 0; i < N; i++) begin
                if (state_q[i] == S_IDLE && cmd_valid[i]) begin
                    cnt_q[i]  <= cmd_len[i*LEN_W +: LEN_W];
                    wait_q[i] <= '0;
                end else if (fire[i]) begin
                    if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - LEN_W'(1);
                    wait_q[i] <= '0;
                end else if (state_q[i] == S_REQ) begin
                    // Saturate at TIMEOUT; starve sets on the edge it is reached.
                    if (wait_q[i] != WAIT_W'(TIMEOUT)) wait_q[i] <= wait_q[i] + WAIT_W'(1);
                    if (wait_q[i] == WAIT_W'(TIMEOUT - 1)) starve_q[i] <= 1'b1;
                end
            end
        end
    end

    // Output decode: handshake, request vector and the beat bus.
    always_comb begin
        cmd_ready  = '0;
        REQ        = active;
        beat_valid = |fire;
        beat_id    = beat_id_q;
        beat_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cmd_ready[i] = (state_q[i] == S_IDLE);
            if (fire[i]) begin
                beat_id   = 2'(i);
                beat_last = (cnt_q[i] == '0);
            end
        end
        starve    = starve_q;
        proto_err = proto_err_q;
    end

endmodule
